// File: rtl/platform_nios_oci_pkg.sv
// Shared definitions for the Nios OCI trace packer slice.
// Holds the packer FSM state enum, the default atom width and frame depth,
// and a constant-evaluable clog2 helper used to size index arithmetic.
package platform_nios_oci_pkg;

    localparam int DEFAULT_ATOM_W = 2;
    localparam int DEFAULT_DEPTH  = 15;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        ENDED = 2'd2
    } packer_state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/platform_nios_oci_sat_counter.sv
// Saturating up-counter used for the packer statistics.
// Ports:
//   clk   - clock
//   clear - synchronous clear, wins over inc
//   inc   - add one this cycle unless already at all-ones
//   count - current value
module platform_nios_oci_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/platform_nios_oci_dct_packer.sv
// Packs ATOM_W-bit OCI trace atoms into DEPTH-atom frames and presents them
// on a valid/ready output. A test_ending pulse flushes the partial frame;
// once test_has_ended is seen the packer refuses atoms and counts drops.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   atom_valid/atom_data/atom_ready - incoming atom handshake
//   dct_valid/dct_buffer/dct_count/dct_ready - outgoing frame handshake,
//                                atom 0 in the LSBs, unused atoms zero
//   test_ending                - one-cycle flush request
//   test_has_ended             - end-of-test level
//   flush_done                 - one-cycle pulse when a flush completes
//   frame_cnt, drop_cnt        - saturating statistics
module platform_nios_oci_dct_packer
    import platform_nios_oci_pkg::*;
#(
    parameter int ATOM_W = DEFAULT_ATOM_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    atom_valid,
    input  logic [ATOM_W-1:0]       atom_data,
    output logic                    atom_ready,
    output logic                    dct_valid,
    output logic [ATOM_W*DEPTH-1:0] dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    input  logic                    dct_ready,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    output logic                    flush_done,
    output logic [STAT_W-1:0]       frame_cnt,
    output logic [STAT_W-1:0]       drop_cnt
);

    localparam int FRAME_W = ATOM_W * DEPTH;
    localparam int IDX_W   = CNT_W + clog2(ATOM_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    packer_state_t        state, state_next;
    logic [FRAME_W-1:0]   acc, acc_next, acc_with;
    logic [CNT_W-1:0]     cnt, cnt_next, cnt_with;
    logic [IDX_W-1:0]     slot_idx;
    logic                 atom_fire;
    logic                 out_free;
    logic                 load;
    logic                 flush_next;

    // Ready is gated by reset so every output reads zero while reset is held.
    assign atom_ready = !reset && (state == FILL) && (cnt < DEPTH_C);
    assign atom_fire  = atom_valid && atom_ready;
    assign out_free   = !dct_valid || dct_ready;

    // Upper accumulator slots are always zero, so OR-ing the shifted atom in
    // is equivalent to writing acc[cnt*ATOM_W +: ATOM_W].
    assign slot_idx = IDX_W'(cnt) * IDX_W'(ATOM_W);
    assign acc_with = atom_fire ? (acc | (FRAME_W'(atom_data) << slot_idx)) : acc;
    assign cnt_with = cnt + {{(CNT_W-1){1'b0}}, atom_fire};

    always_comb begin
        state_next = state;
        acc_next   = acc_with;
        cnt_next   = cnt_with;
        load       = 1'b0;
        flush_next = 1'b0;
        case (state)
            FILL: begin
                // A frame completed this cycle (or earlier, while blocked)
                // moves to the output register as soon as it is free.
                if ((cnt_with == DEPTH_C) && out_free) begin
                    load     = 1'b1;
                    acc_next = '0;
                    cnt_next = '0;
                end
                if (test_ending) begin
                    state_next = FLUSH;
                end else if (test_has_ended) begin
                    state_next = ENDED;
                end
            end
            FLUSH: begin
                // An empty accumulator completes immediately with no frame.
                if ((cnt == '0) || out_free) begin
                    load       = (cnt != '0);
                    acc_next   = '0;
                    cnt_next   = '0;
                    flush_next = 1'b1;
                    state_next = test_has_ended ? ENDED : FILL;
                end
            end
            ENDED: begin
                if ((cnt == DEPTH_C) && out_free) begin
                    load     = 1'b1;
                    acc_next = '0;
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    // Output register: holds its frame while dct_valid && !dct_ready, and a
    // new load on the handshake edge keeps dct_valid high for back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_valid  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= flush_next;
            if (load) begin
                dct_valid  <= 1'b1;
                dct_buffer <= acc_with;
                dct_count  <= cnt_with;
            end else if (dct_valid && dct_ready) begin
                dct_valid <= 1'b0;
            end
        end
    end

    platform_nios_oci_sat_counter #(.WIDTH(STAT_W)) u_frame_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (dct_valid && dct_ready),
        .count (frame_cnt)
    );

    platform_nios_oci_sat_counter #(.WIDTH(STAT_W)) u_drop_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   ((state == ENDED) && atom_valid),
        .count (drop_cnt)
    );

endmodule
